trace_streamer: RTL and testbench

TRACE_STREAMER -- requirements
Module: trace_streamer

---
 rtl/trace_streamer.sv | 150 +++++++++++++++
 tb/tb_trace_streamer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_streamer.sv
// trace_streamer: queues retired instructions and streams one disassembled text line per retire.
// Define TRACE_PC_EN to prefix each line with the 8-digit hex PC, a colon and a space.
module trace_streamer #(
  parameter int STR_LEN    = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 retire_valid,
  input  logic [31:0]          retire_inst,
  input  logic [31:0]          retire_pc,
  input  logic [31:0]          retire_jt,
  input  logic [31:0]          retire_bt,
  output logic [31:0]          dec_inst,
  output logic [31:0]          dec_jump_target,
  output logic [31:0]          dec_branch_target,
  input  logic [STR_LEN*8-1:0] dec_str,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);
`ifdef TRACE_PC_EN
  localparam int EW = 128;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PC, S_STR, S_EOL} state_t;
`else
  localparam int EW = 96;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STR, S_EOL} state_t;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(STR_LEN > 10 ? STR_LEN : 10);

  state_t               r_state, w_next;
  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr, r_rd;
  logic [AW:0]          r_cnt;
  logic [EW-1:0]        r_hold, w_in;
  logic [STR_LEN*8-1:0] r_line;
  logic [IW-1:0]        r_idx;
  logic                 r_overflow;
  logic [7:0]           r_drop;
  logic                 w_full, w_empty, w_push, w_pop, w_drop, w_adv, w_last;
  logic [7:0]           w_chr;

  assign w_full  = r_cnt[AW];
  assign w_empty = r_cnt == '0;
  assign w_pop   = r_state == S_IDLE && !w_empty;
  assign w_push  = retire_valid && (!w_full || w_pop);
  assign w_drop  = retire_valid && w_full && !w_pop;
  assign w_chr   = r_line[STR_LEN*8-1 -: 8];

  assign dec_inst          = r_hold[EW-1 -: 32];
  assign dec_jump_target   = r_hold[63:32];
  assign dec_branch_target = r_hold[31:0];
  assign overflow          = r_overflow;
  assign drop_cnt          = r_drop;

`ifdef TRACE_PC_EN
  logic [31:0] w_pc_sh;
  logic [3:0]  w_nib;
  logic [7:0]  w_pc_chr;
  assign w_in     = {retire_inst, retire_pc, retire_jt, retire_bt};
  assign w_pc_sh  = r_hold[95:64] << {r_idx[2:0], 2'b00};
  assign w_nib    = w_pc_sh[31:28];
  assign w_pc_chr = r_idx == IW'(8) ? 8'h3A : r_idx == IW'(9) ? 8'h20 :
                    w_nib < 4'd10 ? 8'h30 + {4'h0, w_nib} : 8'h37 + {4'h0, w_nib};
  assign w_adv    = (r_state == S_STR && (w_chr == 8'h00 || tx_ready)) || (r_state == S_PC && tx_ready);
  assign w_last   = r_idx == (r_state == S_PC ? IW'(9) : IW'(STR_LEN - 1));
`else
  assign w_in   = {retire_inst, retire_jt, retire_bt};
  assign w_adv  = r_state == S_STR && (w_chr == 8'h00 || tx_ready);
  assign w_last = r_idx == IW'(STR_LEN - 1);
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold <= '0;
      r_line <= '0;
      r_idx  <= '0;
    end else begin
      if (w_pop) r_hold <= r_mem[r_rd];
      if (r_state == S_LOAD) begin
        r_line <= dec_str;
        r_idx  <= '0;
      end else if (w_adv) begin
        r_idx <= w_last ? '0 : r_idx + IW'(1);
        if (r_state == S_STR) r_line <= r_line << 8;
      end
    end
  end

  // Drop accounting is sticky until reset; the counter saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = w_empty ? S_IDLE : S_LOAD;
`ifdef TRACE_PC_EN
      S_LOAD: w_next = S_PC;
      S_PC:   w_next = w_adv && w_last ? S_STR : S_PC;
`else
      S_LOAD: w_next = S_STR;
`endif
      S_STR:  w_next = w_adv && w_last ? S_EOL : S_STR;
      S_EOL:  w_next = tx_ready ? S_IDLE : S_EOL;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef TRACE_PC_EN
    tx_valid = (r_state == S_STR && w_chr != 8'h00) || r_state == S_EOL || r_state == S_PC;
    tx_data  = r_state == S_STR ? w_chr : r_state == S_EOL ? 8'h0A : r_state == S_PC ? w_pc_chr : 8'h00;
`else
    tx_valid = (r_state == S_STR && w_chr != 8'h00) || r_state == S_EOL;
    tx_data  = r_state == S_STR ? w_chr : r_state == S_EOL ? 8'h0A : 8'h00;
`endif
  end
endmodule

// File: tb/tb_trace_streamer.sv
// tb_trace_streamer: directed vector table plus stall, overflow and reset sequences for trace_streamer.
module tb_trace_streamer;
  localparam int SL = 16;
  localparam int FD = 4;
  localparam int NV = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          retire_valid = 1'b0;
  logic [31:0]   retire_inst = '0, retire_pc = '0, retire_jt = '0, retire_bt = '0;
  logic [31:0]   dec_inst, dec_jump_target, dec_branch_target;
  logic [SL*8-1:0] dec_str;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b1;
  logic          overflow;
  logic [7:0]    drop_cnt;

  typedef struct {
    logic [31:0]     inst, pc, jt, bt;
    logic [SL*8-1:0] str;
    string           exp;
  } vec_t;

  vec_t vt [NV];
  byte  rx [$];
  int   total = 0;
  int   bad = 0;

  trace_streamer #(.STR_LEN(SL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .retire_valid(retire_valid),
    .retire_inst(retire_inst), .retire_pc(retire_pc), .retire_jt(retire_jt), .retire_bt(retire_bt),
    .dec_inst(dec_inst), .dec_jump_target(dec_jump_target), .dec_branch_target(dec_branch_target),
    .dec_str(dec_str), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset_n && tx_valid && tx_ready) rx.push_back(tx_data);

  // '~' in a decoder string stands for a 0x00 padding byte
  function automatic logic [SL*8-1:0] pack(string s);
    logic [SL*8-1:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[SL*8-1-8*i -: 8] = (s[i] == 8'h7E) ? 8'h00 : s[i];
    return r;
  endfunction

  function automatic logic [SL*8-1:0] lookup(logic [31:0] inst);
    logic [SL*8-1:0] r = '0;
    for (int i = 0; i < NV; i++) if (vt[i].inst == inst) r = vt[i].str;
    return r;
  endfunction

  assign dec_str = lookup(dec_inst);

  function automatic string vis(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = (s[i] == 8'h0A) ? {r, "\\n"} : $sformatf("%s%c", r, s[i]);
    return r;
  endfunction

  function automatic string rx_str();
    string r = "";
    foreach (rx[i]) r = $sformatf("%s%c", r, rx[i]);
    return r;
  endfunction

  function automatic string full(int i);
`ifdef TRACE_PC_EN
    return $sformatf("%08X: %s", vt[i].pc, vt[i].exp);
`else
    return vt[i].exp;
`endif
  endfunction

  task automatic add(int i, logic [31:0] inst, pc, jt, bt, string s, string e);
    vt[i].inst = inst; vt[i].pc = pc; vt[i].jt = jt; vt[i].bt = bt;
    vt[i].str = pack(s); vt[i].exp = e;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic chk_line(string name, string want);
    string got = rx_str();
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got \"%s\" want \"%s\"", name, vis(got), vis(want));
    end
  endtask

  task automatic drive(int i, logic v);
    retire_valid = v;
    retire_inst = vt[i].inst; retire_pc = vt[i].pc; retire_jt = vt[i].jt; retire_bt = vt[i].bt;
  endtask

  task automatic retire(int i);
    @(negedge clk);
    drive(i, 1'b1);
    @(negedge clk);
    retire_valid = 1'b0;
  endtask

  task automatic wait_bytes(int n);
    for (int c = 0; c < 3000 && rx.size() < n; c++) @(negedge clk);
    repeat (24) @(negedge clk);
  endtask

  initial begin
    string exp5;
    logic [7:0] hd;
    bit ok;
    add(0, 32'h00000013, 32'h000002A0, 32'h000002A4, 32'h000002A8, "nop     ", "nop     \n");
    add(1, 32'h00A00093, 32'h00001004, 32'h11111111, 32'h22222222, "li~ra,10", "lira,10\n");
    add(2, 32'h01E0006F, 32'hDEADBEEC, 32'hDEADBF0A, 32'h00000000, "~~~~jal 0x1E", "jal 0x1E\n");
    add(3, 32'h00113423, 32'hFFFFFFFC, 32'hCAFEF00D, 32'h12345678, "sd ra,8(sp) ;abc", "sd ra,8(sp) ;abc\n");
    add(4, 32'h00000073, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A, "", "\n");

    repeat (2) @(negedge clk);
    chk("rst tx_valid", 32'(tx_valid), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst dec_inst", dec_inst, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: valid presented in cycle N, first character in cycle N+3
    rx.delete();
    drive(0, 1'b1);
    @(negedge clk);
    retire_valid = 1'b0;
    @(negedge clk);
    chk("lat N+2 idle", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("lat N+3 valid", 32'(tx_valid), 32'd1);
`ifdef TRACE_PC_EN
    chk("lat N+3 data", 32'(tx_data), 32'h30);
`else
    chk("lat N+3 data", 32'(tx_data), 32'h6E);
`endif
    wait_bytes(full(0).len());
    chk_line("lat line", full(0));

    for (int i = 0; i < NV; i++) begin
      rx.delete();
      retire(i);
      wait_bytes(full(i).len());
      chk_line($sformatf("vec%0d line", i), full(i));
      chk($sformatf("vec%0d dec_inst", i), dec_inst, vt[i].inst);
      chk($sformatf("vec%0d dec_jt", i), dec_jump_target, vt[i].jt);
      chk($sformatf("vec%0d dec_bt", i), dec_branch_target, vt[i].bt);
    end

    // Back-pressure mid-line must freeze the character
    rx.delete();
    retire(3);
    for (int c = 0; c < 200 && rx.size() < 4; c++) @(negedge clk);
    tx_ready = 1'b0;
    hd = tx_data;
    chk("stall valid", 32'(tx_valid), 32'd1);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== hd) ok = 1'b0;
    end
    chk("stall hold 5 cycles", 32'(ok), 32'd1);
    tx_ready = 1'b1;
    wait_bytes(full(3).len());
    chk_line("stall line", full(3));

    // Six back-to-back retires into a depth-4 queue: one drop, five lines
    rx.delete();
    tx_ready = 1'b0;
    @(negedge clk);
    repeat (6) begin
      drive(0, 1'b1);
      @(negedge clk);
    end
    retire_valid = 1'b0;
    @(negedge clk);
    chk("ovf drop_cnt", 32'(drop_cnt), 32'd1);
    chk("ovf overflow", 32'(overflow), 32'd1);
    tx_ready = 1'b1;
    exp5 = {full(0), full(0), full(0), full(0), full(0)};
    wait_bytes(exp5.len());
    chk("ovf byte count", 32'(rx.size()), 32'(exp5.len()));
    chk_line("ovf five lines", exp5);
    chk("ovf sticky", 32'(overflow), 32'd1);

    // Saturation and a reset pulse in the middle of a stalled line
    tx_ready = 1'b0;
    @(negedge clk);
    repeat (300) begin
      drive(0, 1'b1);
      @(negedge clk);
    end
    retire_valid = 1'b0;
    @(negedge clk);
    chk("sat drop_cnt", 32'(drop_cnt), 32'd255);
    chk("sat overflow", 32'(overflow), 32'd1);
    chk("sat mid-line valid", 32'(tx_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst tx_valid", 32'(tx_valid), 32'd0);
    chk("arst tx_data", 32'(tx_data), 32'd0);
    chk("arst drop_cnt", 32'(drop_cnt), 32'd0);
    chk("arst overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tx_ready = 1'b1;
    rx.delete();
    @(negedge clk);
    retire(1);
    wait_bytes(full(1).len());
    chk_line("post-reset line", full(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
